mult_seq_nbit: RTL and testbench

MULT_SEQ_NBIT -- requirements
Module: mult_seq_nbit

---
 rtl/mult_seq_nbit.sv | 147 ++++++++++++++
 tb/tb_mult_seq_nbit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mult_seq_nbit.sv
// Sequential shift-and-add unsigned multiplier: one accumulate-and-shift per cycle,
// N RUN cycles per operand pair, result registered on the final RUN edge.

module AdderNbit #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one add/shift step per edge, N edges in total
// DONE  | product valid, done pulses for this single cycle
module mult_seq_nbit #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   p_hi_q, p_hi_d;
    logic [N-1:0]   q_q, q_d;
    logic           c_q, c_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           cout;
    logic [2*N:0]   shifted;
    logic           last_run;
    logic           unused_c;

    assign addend = q_q[0] ? a_q : '0;

    AdderNbit #(.N(N)) u_adder (
        .a    (p_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The carry enters at the top of the 2N+1-bit shift, so (2^N-1)^2 stays exact.
    assign shifted  = {cout, sum, q_q} >> 1;
    assign last_run = (cnt_q == CW'(N - 1));

    // C always shifts back to zero; it is kept as state but nothing consumes it.
    assign unused_c = c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_run) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d       = a_q;
        p_hi_d    = p_hi_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a;
                    q_d    = b;
                    p_hi_d = '0;
                    c_d    = 1'b0;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                {c_d, p_hi_d, q_d} = shifted;
                cnt_d              = cnt_q + CW'(1);
                if (last_run) begin
                    product_d = shifted[2*N-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            p_hi_q    <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            p_hi_q    <= p_hi_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_mult_seq_nbit.sv
// Directed and exhaustive checks of mult_seq_nbit (N=6) with a queue of expected products.

module tb_mult_seq_nbit;

    localparam int N = 6;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    int n_checks  = 0;
    int n_pass    = 0;
    int done_cnt  = 0;
    int n_started = 0;
    int done_base = 0;

    logic [2*N-1:0] sb[$];
    logic [2*N-1:0] mon_exp;

    mult_seq_nbit #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every done pulse must match the oldest outstanding expected product.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            chk("pending_op", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("product", 32'(product), 32'(mon_exp));
            end
        end
    end

    // Starts in an IDLE cycle, returns #1 after the edge that puts the DUT back in IDLE.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input bit detail);
        logic [2*N-1:0] prev;
        logic [2*N-1:0] expv;
        expv  = (2*N)'(av) * (2*N)'(bv);
        prev  = product;
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back(expv);
        n_started++;
        @(posedge clk); #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        if (detail) begin
            chk("busy_accept", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
        end
        for (int i = 1; i <= N; i++) begin
            @(posedge clk); #1;
            if (detail) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_timing", 32'(done), 32'(i == N));
                if (i < N) chk("product_stable_run", 32'(product), 32'(prev));
            end
        end
        @(posedge clk); #1;
        if (detail) begin
            chk("busy_after", 32'(busy), 32'd0);
            chk("done_after", 32'(done), 32'd0);
            chk("product_hold", 32'(product), 32'(expv));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a     = 6'd5;
        b     = 6'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // start still high: first edge with rst low must accept it
        rst = 1'b0;
        run_op(6'd5, 6'd7, 1'b1);
        chk("basic_5x7", 32'(product), 32'h023);
        run_op(6'd63, 6'd63, 1'b1);
        chk("full_scale", 32'(product), 32'hF81);
        run_op(6'd0, 6'd45, 1'b1);
        chk("zero_a", 32'(product), 32'd0);
        run_op(6'd45, 6'd1, 1'b1);
        chk("times_one", 32'(product), 32'd45);

        // start re-pulsed with new operands mid-RUN must be ignored
        done_base = done_cnt;
        a = 6'd9; b = 6'd10; start = 1'b1;
        sb.push_back(12'd90);
        n_started++;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 6'd63; b = 6'd63;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_done", 32'(done), 32'd1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            chk("no_restart_busy", 32'(busy), 32'd0);
        end
        chk("ignored_product", 32'(product), 32'd90);
        chk("single_done", 32'(done_cnt - done_base), 32'd1);

        // reset mid-RUN aborts with no done pulse
        done_base = done_cnt;
        a = 6'd20; b = 6'd30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
        run_op(6'd20, 6'd30, 1'b1);
        chk("restart_20x30", 32'(product), 32'd600);

        // every operand pair at the minimum issue interval
        for (int ai = 0; ai < 64; ai++) begin
            for (int bi = 0; bi < 64; bi++) begin
                run_op(6'(ai), 6'(bi), 1'b0);
            end
        end
        @(posedge clk); #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(n_started));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
